// File: rtl/param_serializer.sv
// rtl/param_serializer.sv - multi-lane parallel-to-serial converter with comma idle insertion
// Optional: define PS_STATS_EN to add the data_word_cnt transferred-word counter.
module param_serializer #(
    parameter int              WIDTH      = 8,
    parameter int              LANES      = 1,
    parameter logic [WIDTH-1:0] IDLE_SYM  = 8'hBC,
    parameter int              SYNC_WORDS = 4,
    parameter bit              MSB_FIRST  = 1'b1
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   force_idle,
    output logic                   in_ready,
    output logic [LANES-1:0]       ser_out,
    output logic                   frame_start,
    output logic                   word_is_data,
    output logic                   active
`ifdef PS_STATS_EN
    ,
    output logic [15:0]            data_word_cnt
`endif
);
    localparam int CW  = $clog2(WIDTH);
    localparam int SCW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [SCW-1:0] SYNC_LAST = SCW'((SYNC_WORDS > 0) ? SYNC_WORDS - 1 : 0);

    typedef enum logic {SYNC, ACTIVE} state_t;

    logic [LANES-1:0][WIDTH-1:0] sh;
    logic [CW-1:0]               cnt;
    logic [SCW-1:0]              sync_cnt;
    state_t                      state;
    logic                        load;
    logic                        xfer;

    assign load     = (cnt == CNT_LAST);
    assign in_ready = (state == ACTIVE) && load && !force_idle && !reset;
    assign xfer     = in_valid && in_ready;
    assign active   = (state == ACTIVE);

    // Output bit taken straight from the shift register end so no input reaches ser_out combinationally.
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        assign ser_out[n] = MSB_FIRST ? sh[n][WIDTH-1] : sh[n][0];
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sh           <= '0;
            cnt          <= CNT_LAST;
            sync_cnt     <= '0;
            state        <= (SYNC_WORDS == 0) ? ACTIVE : SYNC;
            word_is_data <= 1'b0;
            frame_start  <= 1'b0;
        end else if (load) begin
            cnt          <= '0;
            frame_start  <= 1'b1;
            word_is_data <= xfer;
            if (xfer) begin
                sh <= in_data;
            end else begin
                sh <= {LANES{IDLE_SYM}};
            end
            if (state == SYNC) begin
                sync_cnt <= sync_cnt + 1'b1;
                if (sync_cnt == SYNC_LAST) begin
                    state <= ACTIVE;
                end
            end
        end else begin
            cnt         <= cnt + 1'b1;
            frame_start <= 1'b0;
            for (int n = 0; n < LANES; n++) begin
                if (MSB_FIRST) begin
                    sh[n] <= {sh[n][WIDTH-2:0], 1'b0};
                end else begin
                    sh[n] <= {1'b0, sh[n][WIDTH-1:1]};
                end
            end
        end
    end

`ifdef PS_STATS_EN
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            data_word_cnt <= '0;
        end else if (xfer) begin
            data_word_cnt <= data_word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_param_serializer.sv
// tb/tb_param_serializer.sv - scoreboard bench for param_serializer (single-lane MSB-first and dual-lane LSB-first)
module tb_param_serializer;
    logic clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    logic       reset      = 1'b1;
    logic       in_valid   = 1'b0;
    logic       force_idle = 1'b0;
    logic [7:0] in_data    = 8'h00;
    logic       in_ready, frame_start, word_is_data, active;
    logic [0:0] ser_out;

    logic        reset_b      = 1'b1;
    logic        in_valid_b   = 1'b0;
    logic        force_idle_b = 1'b0;
    logic [15:0] in_data_b    = 16'h0000;
    logic        in_ready_b, frame_start_b, word_is_data_b, active_b;
    logic [1:0]  ser_out_b;
`ifdef PS_STATS_EN
    logic [15:0] dwc_a, dwc_b;
`endif

    param_serializer #(
        .WIDTH(8), .LANES(1), .IDLE_SYM(8'hBC), .SYNC_WORDS(4), .MSB_FIRST(1'b1)
    ) dut_a (
        .clk_32f(clk_32f), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .force_idle(force_idle), .in_ready(in_ready), .ser_out(ser_out),
        .frame_start(frame_start), .word_is_data(word_is_data), .active(active)
`ifdef PS_STATS_EN
        , .data_word_cnt(dwc_a)
`endif
    );

    param_serializer #(
        .WIDTH(8), .LANES(2), .IDLE_SYM(8'hBC), .SYNC_WORDS(0), .MSB_FIRST(1'b0)
    ) dut_b (
        .clk_32f(clk_32f), .reset(reset_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .force_idle(force_idle_b), .in_ready(in_ready_b), .ser_out(ser_out_b),
        .frame_start(frame_start_b), .word_is_data(word_is_data_b), .active(active_b)
`ifdef PS_STATS_EN
        , .data_word_cnt(dwc_b)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [2:0] ph  = 3'd7;
    logic [7:0]  exp_a[$];
    logic [15:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Bench-side word phase: 7 marks the load cycle of dut_a.
    always @(posedge clk_32f) begin
        cyc <= cyc + 1;
        ph  <= reset ? 3'd7 : ph + 3'd1;
    end

    logic [7:0] mon_a_word;
    int         mon_a_n = 0;
    logic       mon_a_wid, mon_a_ok;
    int         data_seen_a = 0;
    always @(negedge clk_32f) begin
        if (reset) begin
            mon_a_n = 0;
        end else begin
            if (frame_start) begin
                check("a_frame_align", 32'(mon_a_n), 32'd0);
                mon_a_word = {7'd0, ser_out[0]};
                mon_a_n    = 1;
                mon_a_wid  = word_is_data;
                mon_a_ok   = 1'b1;
            end else if (mon_a_n > 0) begin
                mon_a_word = {mon_a_word[6:0], ser_out[0]};
                mon_a_n++;
                if (word_is_data !== mon_a_wid) mon_a_ok = 1'b0;
            end
            if (mon_a_n == 8) begin
                mon_a_n = 0;
                check("a_flag_steady", 32'(mon_a_ok), 32'd1);
                if (mon_a_wid) begin
                    data_seen_a++;
                    check("a_data_expected", 32'(exp_a.size() > 0), 32'd1);
                    if (exp_a.size() > 0) check("a_data_word", 32'(mon_a_word), 32'(exp_a.pop_front()));
                end else begin
                    check("a_idle_word", 32'(mon_a_word), 32'h000000BC);
                end
            end
        end
    end

    logic [7:0] mon_b_w0, mon_b_w1;
    int         mon_b_n = 0;
    logic       mon_b_wid, mon_b_ok;
    int         data_seen_b = 0;
    always @(negedge clk_32f) begin
        if (reset_b) begin
            mon_b_n = 0;
        end else begin
            if (frame_start_b) begin
                check("b_frame_align", 32'(mon_b_n), 32'd0);
                mon_b_w0  = {ser_out_b[0], 7'd0};
                mon_b_w1  = {ser_out_b[1], 7'd0};
                mon_b_n   = 1;
                mon_b_wid = word_is_data_b;
                mon_b_ok  = 1'b1;
            end else if (mon_b_n > 0) begin
                mon_b_w0 = {ser_out_b[0], mon_b_w0[7:1]};
                mon_b_w1 = {ser_out_b[1], mon_b_w1[7:1]};
                mon_b_n++;
                if (word_is_data_b !== mon_b_wid) mon_b_ok = 1'b0;
            end
            if (mon_b_n == 8) begin
                mon_b_n = 0;
                check("b_flag_steady", 32'(mon_b_ok), 32'd1);
                if (mon_b_wid) begin
                    data_seen_b++;
                    check("b_data_expected", 32'(exp_b.size() > 0), 32'd1);
                    if (exp_b.size() > 0) check("b_data_lanes", 32'({mon_b_w1, mon_b_w0}), 32'(exp_b.pop_front()));
                end else begin
                    check("b_idle_lanes", 32'({mon_b_w1, mon_b_w0}), 32'h0000BCBC);
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] d, input bit hold, input bit keep_exp, output int xcyc);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk_32f);
        while (!in_ready && guard < 100) begin
            @(negedge clk_32f);
            guard++;
        end
        check("a_accept", 32'(in_ready), 32'd1);
        if (in_ready && keep_exp) exp_a.push_back(d);
        xcyc = cyc;
        @(posedge clk_32f);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d, input bit hold, output int xcyc);
        int guard = 0;
        in_valid_b = 1'b1;
        in_data_b  = d;
        @(negedge clk_32f);
        while (!in_ready_b && guard < 100) begin
            @(negedge clk_32f);
            guard++;
        end
        check("b_accept", 32'(in_ready_b), 32'd1);
        if (in_ready_b) exp_b.push_back(d);
        xcyc = cyc;
        @(posedge clk_32f);
        #1;
        if (!hold) in_valid_b = 1'b0;
    endtask

    // Called right after reset release; cycle 0 is the first (load) cycle out of reset.
    task automatic check_sync();
        int first_rdy = -1;
        int rdy_cnt   = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk_32f);
            if (k == 0) begin
                check("sync_active_k0", 32'(active), 32'd0);
                check("sync_fs_k0", 32'(frame_start), 32'd0);
                check("sync_ser_k0", 32'(ser_out), 32'd0);
            end
            if (k == 1 || k == 9) check("sync_fs_word_start", 32'(frame_start), 32'd1);
            if (k == 1) check("sync_first_bit", 32'(ser_out), 32'd1);
            if (k == 24) check("sync_active_k24", 32'(active), 32'd0);
            if (k == 25) check("sync_active_k25", 32'(active), 32'd1);
            if (in_ready && first_rdy < 0) first_rdy = k;
            if (k >= 32 && in_ready) rdy_cnt++;
        end
        check("sync_first_ready", 32'(first_rdy), 32'd32);
        check("sync_ready_rate", 32'(rdy_cnt), 32'd4);
    endtask

    initial begin
        int t0, t1, t2, tdrop, guard;

        // Reset state
        repeat (2) @(posedge clk_32f);
        @(negedge clk_32f);
        check("rst_ser_out", 32'(ser_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_word_is_data", 32'(word_is_data), 32'd0);
        @(posedge clk_32f);
        #1 reset = 1'b0;
        check_sync();

        // Single data word and its latency
        send_a(8'hA5, 1'b0, 1'b1, t0);
        @(negedge clk_32f);
        check("a5_frame_start", 32'(frame_start), 32'd1);
        check("a5_first_bit", 32'(ser_out), 32'd1);
        check("a5_is_data", 32'(word_is_data), 32'd1);
`ifdef PS_STATS_EN
        check("a5_stat_cnt", 32'(dwc_a), 32'd1);
`endif

        // Back-to-back stream
        send_a(8'h01, 1'b1, 1'b1, t0);
        send_a(8'hFF, 1'b1, 1'b1, t1);
        send_a(8'h00, 1'b0, 1'b1, t2);
        check("b2b_gap_1", 32'(t1 - t0), 32'd8);
        check("b2b_gap_2", 32'(t2 - t1), 32'd8);

        // force_idle holds off a pending word for two load cycles
        guard = 0;
        do begin
            @(negedge clk_32f);
            guard++;
        end while (ph != 3'd0 && guard < 20);
        force_idle = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h3C;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_32f);
            if (ph == 3'd7) check("force_idle_ready", 32'(in_ready), 32'd0);
        end
        force_idle = 1'b0;
        tdrop = cyc;
        send_a(8'h3C, 1'b0, 1'b1, t0);
        check("force_release_load", 32'(t0 - tdrop), 32'd7);

        // Reset in the middle of a data word
        send_a(8'hFF, 1'b0, 1'b0, t0);
        guard = 0;
        do begin
            @(negedge clk_32f);
            guard++;
        end while (ph != 3'd3 && guard < 20);
        reset = 1'b1;
        @(posedge clk_32f);
        #1;
        @(negedge clk_32f);
        check("midrst_ser_out", 32'(ser_out), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
`ifdef PS_STATS_EN
        check("midrst_stat_cnt", 32'(dwc_a), 32'd0);
`endif
        @(posedge clk_32f);
        #1 reset = 1'b0;
        check_sync();

        // Dual lane, LSB first, no sync phase
        in_valid_b = 1'b1;
        in_data_b  = {8'hF0, 8'h0F};
        @(posedge clk_32f);
        #1 reset_b = 1'b0;
        @(negedge clk_32f);
        check("b_active_now", 32'(active_b), 32'd1);
        check("b_ready_now", 32'(in_ready_b), 32'd1);
        if (in_ready_b) exp_b.push_back(in_data_b);
        t0 = cyc;
        @(posedge clk_32f);
        #1;
        in_data_b = {8'h0F, 8'hF0};
        @(negedge clk_32f);
        check("b_frame_start", 32'(frame_start_b), 32'd1);
        check("b_first_bits", 32'(ser_out_b), 32'd1);
        send_b({8'h0F, 8'hF0}, 1'b0, t1);
        check("b_b2b_gap", 32'(t1 - t0), 32'd8);

        repeat (40) @(negedge clk_32f);
        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check("a_data_words", 32'(data_seen_a), 32'd5);
        check("b_data_words", 32'(data_seen_b), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
